// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the two-port RAM arbiter: FSM encoding, port
// indices and the byte-mask to bit-mask expansion helper.
package mem_port_arbiter_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        RMW_WR = 1'b1
    } state_e;

    localparam int P_FETCH = 0;
    localparam int P_LSU   = 1;

    // Widest word the mask helper supports, in bytes; callers zero-extend.
    localparam int MAX_BYTES = 128;

    // Replicate each byte-enable bit across its 8-bit lane.
    function automatic logic [MAX_BYTES*8-1:0] expand_mask(input logic [MAX_BYTES-1:0] m);
        logic [MAX_BYTES*8-1:0] r;
        r = '0;
        for (int k = 0; k < MAX_BYTES; k++) begin
            r[8*k +: 8] = {8{m[k]}};
        end
        return r;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter. A lone requester always wins; on a conflict
// the port named by rr_ptr wins. After every accept the pointer moves to the
// port that lost, so the loser of this cycle has priority next time.
module rr_arbiter2 (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] grant
);

    logic rr_ptr_q;
    logic rr_ptr_d;

    // One-hot grant from the request vector and the priority pointer.
    always_comb begin
        grant = 2'b00;
        if (req == 2'b11) begin
            grant = rr_ptr_q ? 2'b10 : 2'b01;
        end else begin
            grant = req;
        end
    end

    // Pointer moves to the non-granted port only when a request is taken.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (accept) begin
            rr_ptr_d = grant[0];
        end
    end

    // Pointer register; port 0 has priority out of reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            rr_ptr_q <= 1'b0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one combinational-read single-port RAM between the fetch port (p0)
// and the load/store port (p1). Reads, full writes and null writes take one
// cycle; partial-mask writes read the word in the accept cycle and write the
// merged word in a following RMW_WR cycle during which both ports stall.
//
// Handshake: a request transfers in the cycle where pN_req_valid and
// pN_req_ready are both high; ready never depends on the response side.
// pN_rsp_valid is a single-cycle pulse with no back-pressure.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 1024,
    localparam int AW   = $clog2(DEPTH),
    localparam int NB   = WIDTH / 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             p0_req_valid,
    output logic             p0_req_ready,
    input  logic [AW-1:0]    p0_addr,
    input  logic             p0_we,
    input  logic [NB-1:0]    p0_wmask,
    input  logic [WIDTH-1:0] p0_wdata,
    output logic             p0_rsp_valid,
    output logic [WIDTH-1:0] p0_rsp_data,
    input  logic             p1_req_valid,
    output logic             p1_req_ready,
    input  logic [AW-1:0]    p1_addr,
    input  logic             p1_we,
    input  logic [NB-1:0]    p1_wmask,
    input  logic [WIDTH-1:0] p1_wdata,
    output logic             p1_rsp_valid,
    output logic [WIDTH-1:0] p1_rsp_data,
    output logic             ram_we,
    output logic [AW-1:0]    ram_addr,
    output logic [WIDTH-1:0] ram_wdata,
    input  logic [WIDTH-1:0] ram_rdata,
    output state_e           dbg_state
);

    state_e            state_q, state_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic              owner_q, owner_d;
    logic [WIDTH-1:0]  merged_q, merged_d;
    logic [AW-1:0]     last_addr_q, last_addr_d;
    logic [1:0]        rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0]  rsp_data0_q, rsp_data0_d;
    logic [WIDTH-1:0]  rsp_data1_q, rsp_data1_d;

    logic [1:0]        req;
    logic [1:0]        grant;
    logic              accept;
    logic              can_accept;

    logic [AW-1:0]     sel_addr;
    logic              sel_we;
    logic [NB-1:0]     sel_mask;
    logic [WIDTH-1:0]  sel_wdata;
    logic              sel_full;
    logic              sel_partial;

    logic [MAX_BYTES-1:0]   mask_ext;
    logic [MAX_BYTES*8-1:0] mask_bits_all;
    logic [WIDTH-1:0]       bit_mask;
    logic                   unused_mask_hi;

    assign req        = {p1_req_valid, p0_req_valid};
    assign can_accept = (state_q == IDLE) && !reset;
    assign accept     = can_accept && (grant != 2'b00);

    assign p0_req_ready = can_accept && grant[P_FETCH];
    assign p1_req_ready = can_accept && grant[P_LSU];

    rr_arbiter2 u_rr (
        .clock  (clock),
        .reset  (reset),
        .req    (req),
        .accept (accept),
        .grant  (grant)
    );

    // Fields of whichever request is granted this cycle.
    always_comb begin
        sel_addr  = grant[P_LSU] ? p1_addr  : p0_addr;
        sel_we    = grant[P_LSU] ? p1_we    : p0_we;
        sel_mask  = grant[P_LSU] ? p1_wmask : p0_wmask;
        sel_wdata = grant[P_LSU] ? p1_wdata : p0_wdata;
    end

    // Byte-lane mask expanded to a per-bit mask for the merge.
    always_comb begin
        mask_ext           = '0;
        mask_ext[NB-1:0]   = sel_mask;
        mask_bits_all      = expand_mask(mask_ext);
        bit_mask           = mask_bits_all[WIDTH-1:0];
        unused_mask_hi     = ^mask_bits_all;
        sel_full           = (sel_mask == {NB{1'b1}});
        sel_partial        = (sel_mask != '0) && !sel_full;
    end

    // RAM drive: direct write for full masks, merged word in RMW_WR; the
    // address holds its previous value when nothing is happening.
    always_comb begin
        ram_we    = 1'b0;
        ram_addr  = last_addr_q;
        ram_wdata = merged_q;
        if (state_q == RMW_WR) begin
            ram_we    = !reset;
            ram_addr  = addr_q;
            ram_wdata = merged_q;
        end else if (accept) begin
            ram_we    = sel_we && sel_full;
            ram_addr  = sel_addr;
            ram_wdata = sel_wdata;
        end
    end

    // Next-state, RMW capture and response generation.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        owner_d     = owner_q;
        merged_d    = merged_q;
        last_addr_d = ram_addr;
        rsp_valid_d = 2'b00;
        rsp_data0_d = rsp_data0_q;
        rsp_data1_d = rsp_data1_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (sel_we && sel_partial) begin
                        state_d  = RMW_WR;
                        addr_d   = sel_addr;
                        owner_d  = grant[P_LSU];
                        merged_d = (ram_rdata & ~bit_mask) | (sel_wdata & bit_mask);
                    end else if (grant[P_LSU]) begin
                        rsp_valid_d[P_LSU] = 1'b1;
                        rsp_data1_d        = (sel_we && sel_full) ? sel_wdata : ram_rdata;
                    end else begin
                        rsp_valid_d[P_FETCH] = 1'b1;
                        rsp_data0_d          = (sel_we && sel_full) ? sel_wdata : ram_rdata;
                    end
                end
            end
            RMW_WR: begin
                state_d = IDLE;
                if (owner_q) begin
                    rsp_valid_d[P_LSU] = 1'b1;
                    rsp_data1_d        = merged_q;
                end else begin
                    rsp_valid_d[P_FETCH] = 1'b1;
                    rsp_data0_d          = merged_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs; reset drops any pending RMW write.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            owner_q     <= 1'b0;
            merged_q    <= '0;
            last_addr_q <= '0;
            rsp_valid_q <= 2'b00;
            rsp_data0_q <= '0;
            rsp_data1_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            owner_q     <= owner_d;
            merged_q    <= merged_d;
            last_addr_q <= last_addr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data0_q <= rsp_data0_d;
            rsp_data1_q <= rsp_data1_d;
        end
    end

    assign p0_rsp_valid = rsp_valid_q[P_FETCH];
    assign p1_rsp_valid = rsp_valid_q[P_LSU];
    assign p0_rsp_data  = rsp_data0_q;
    assign p1_rsp_data  = rsp_data1_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural combinational-read
// RAM attached. Inputs change on the falling edge; outputs are sampled on
// the falling edge (registered) or 1 time unit later (combinational).
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    localparam int WIDTH = 32;
    localparam int DEPTH = 1024;
    localparam int AW    = 10;
    localparam int NB    = 4;

    logic             clock;
    logic             reset;
    logic             p0_req_valid, p1_req_valid;
    logic             p0_req_ready, p1_req_ready;
    logic [AW-1:0]    p0_addr, p1_addr;
    logic             p0_we, p1_we;
    logic [NB-1:0]    p0_wmask, p1_wmask;
    logic [WIDTH-1:0] p0_wdata, p1_wdata;
    logic             p0_rsp_valid, p1_rsp_valid;
    logic [WIDTH-1:0] p0_rsp_data, p1_rsp_data;
    logic             ram_we;
    logic [AW-1:0]    ram_addr;
    logic [WIDTH-1:0] ram_wdata;
    logic [WIDTH-1:0] ram_rdata;
    state_e           dbg_state;

    logic [WIDTH-1:0] mem [DEPTH];

    int vectors;
    int miscompares;

    mem_port_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clock        (clock),
        .reset        (reset),
        .p0_req_valid (p0_req_valid),
        .p0_req_ready (p0_req_ready),
        .p0_addr      (p0_addr),
        .p0_we        (p0_we),
        .p0_wmask     (p0_wmask),
        .p0_wdata     (p0_wdata),
        .p0_rsp_valid (p0_rsp_valid),
        .p0_rsp_data  (p0_rsp_data),
        .p1_req_valid (p1_req_valid),
        .p1_req_ready (p1_req_ready),
        .p1_addr      (p1_addr),
        .p1_we        (p1_we),
        .p1_wmask     (p1_wmask),
        .p1_wdata     (p1_wdata),
        .p1_rsp_valid (p1_rsp_valid),
        .p1_rsp_data  (p1_rsp_data),
        .ram_we       (ram_we),
        .ram_addr     (ram_addr),
        .ram_wdata    (ram_wdata),
        .ram_rdata    (ram_rdata),
        .dbg_state    (dbg_state)
    );

    // Clock and RAM model
    initial clock = 1'b0;
    always #5 clock = ~clock;

    assign ram_rdata = mem[ram_addr];
    always @(posedge clock) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
    end

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic set_p0(input logic v, input logic [AW-1:0] a, input logic w,
                          input logic [NB-1:0] m, input logic [WIDTH-1:0] d);
        p0_req_valid = v; p0_addr = a; p0_we = w; p0_wmask = m; p0_wdata = d;
    endtask

    task automatic set_p1(input logic v, input logic [AW-1:0] a, input logic w,
                          input logic [NB-1:0] m, input logic [WIDTH-1:0] d);
        p1_req_valid = v; p1_addr = a; p1_we = w; p1_wmask = m; p1_wdata = d;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        set_p0(1'b0, '0, 1'b0, '0, '0);
        set_p1(1'b0, '0, 1'b0, '0, '0);

        // Reset: ready and ram_we held low even with a valid request
        @(negedge clock);
        set_p0(1'b1, 10'd0, 1'b0, 4'h0, 32'h0);
        #1;
        chk("rst_ready0", 32'(p0_req_ready), 32'd0);
        chk("rst_ram_we", 32'(ram_we), 32'd0);
        step();
        reset = 1'b0;
        set_p0(1'b0, 10'd0, 1'b0, 4'h0, 32'h0);
        #1;
        chk("idle_ram_we", 32'(ram_we), 32'd0);
        chk("idle_rv0", 32'(p0_rsp_valid), 32'd0);
        chk("idle_rv1", 32'(p1_rsp_valid), 32'd0);
        chk("idle_rd0", p0_rsp_data, 32'd0);
        chk("idle_rd1", p1_rsp_data, 32'd0);
        chk("idle_state", 32'(dbg_state), 32'(IDLE));
        set_p0(1'b1, 10'd0, 1'b0, 4'h0, 32'h0);
        #1;
        chk("first_ready0", 32'(p0_req_ready), 32'd1);
        step();
        set_p0(1'b0, 10'd0, 1'b0, 4'h0, 32'h0);
        chk("first_rv0", 32'(p0_rsp_valid), 32'd1);

        // Preload via full writes on p1
        set_p1(1'b1, 10'd5, 1'b1, 4'hF, 32'hDEADBEEF);
        #1;
        chk("fw5_ready1", 32'(p1_req_ready), 32'd1);
        chk("fw5_ram_we", 32'(ram_we), 32'd1);
        chk("fw5_wdata", ram_wdata, 32'hDEADBEEF);
        step();
        set_p1(1'b1, 10'd3, 1'b1, 4'hF, 32'h11223344);
        chk("fw5_rv1", 32'(p1_rsp_valid), 32'd1);
        chk("fw5_rd1", p1_rsp_data, 32'hDEADBEEF);
        step();
        set_p1(1'b0, 10'd0, 1'b0, 4'h0, 32'h0);
        chk("fw3_rd1", p1_rsp_data, 32'h11223344);

        // p0 read of addr 5
        set_p0(1'b1, 10'd5, 1'b0, 4'h0, 32'h0);
        #1;
        chk("rd5_ready0", 32'(p0_req_ready), 32'd1);
        chk("rd5_ram_we", 32'(ram_we), 32'd0);
        chk("rd5_addr", 32'(ram_addr), 32'd5);
        step();
        set_p0(1'b0, 10'd0, 1'b0, 4'h0, 32'h0);
        chk("rd5_rv0", 32'(p0_rsp_valid), 32'd1);
        chk("rd5_rd0", p0_rsp_data, 32'hDEADBEEF);
        step();
        chk("rd5_rv0_once", 32'(p0_rsp_valid), 32'd0);

        // Continuous reads from both ports straight out of reset
        reset = 1'b1;
        set_p0(1'b1, 10'd5, 1'b0, 4'h0, 32'h0);
        set_p1(1'b1, 10'd3, 1'b0, 4'h0, 32'h0);
        step();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("cr_ready0", 32'(p0_req_ready), 32'((i % 2) == 0));
            chk("cr_ready1", 32'(p1_req_ready), 32'((i % 2) == 1));
            step();
            chk("cr_rv0", 32'(p0_rsp_valid), 32'((i % 2) == 0));
            chk("cr_rv1", 32'(p1_rsp_valid), 32'((i % 2) == 1));
            if ((i % 2) == 0) chk("cr_rd0", p0_rsp_data, 32'hDEADBEEF);
            else              chk("cr_rd1", p1_rsp_data, 32'h11223344);
        end
        set_p0(1'b0, 10'd0, 1'b0, 4'h0, 32'h0);
        set_p1(1'b0, 10'd0, 1'b0, 4'h0, 32'h0);
        step();
        chk("cr_quiet0", 32'(p0_rsp_valid), 32'd0);
        chk("cr_quiet1", 32'(p1_rsp_valid), 32'd0);

        // p1 partial write to addr 3, p0 read queued behind it
        set_p1(1'b1, 10'd3, 1'b1, 4'b0010, 32'h0000AB00);
        #1;
        chk("pw_ready1", 32'(p1_req_ready), 32'd1);
        chk("pw_acc_we", 32'(ram_we), 32'd0);
        step();
        set_p1(1'b0, 10'd0, 1'b0, 4'h0, 32'h0);
        set_p0(1'b1, 10'd3, 1'b0, 4'h0, 32'h0);
        #1;
        chk("pw_state", 32'(dbg_state), 32'(RMW_WR));
        chk("pw_ram_we", 32'(ram_we), 32'd1);
        chk("pw_wdata", ram_wdata, 32'h1122AB44);
        chk("pw_addr", 32'(ram_addr), 32'd3);
        chk("pw_stall0", 32'(p0_req_ready), 32'd0);
        chk("pw_stall1", 32'(p1_req_ready), 32'd0);
        chk("pw_early_rv1", 32'(p1_rsp_valid), 32'd0);
        step();
        chk("pw_rv1", 32'(p1_rsp_valid), 32'd1);
        chk("pw_rd1", p1_rsp_data, 32'h1122AB44);
        #1;
        chk("pw_after_ready0", 32'(p0_req_ready), 32'd1);
        step();
        set_p0(1'b0, 10'd0, 1'b0, 4'h0, 32'h0);
        chk("pw_read_rv0", 32'(p0_rsp_valid), 32'd1);
        chk("pw_read_rd0", p0_rsp_data, 32'h1122AB44);

        // Full write on p1 then p0 reads it in the following cycle
        set_p1(1'b1, 10'd7, 1'b1, 4'hF, 32'hCAFEF00D);
        step();
        set_p1(1'b0, 10'd0, 1'b0, 4'h0, 32'h0);
        set_p0(1'b1, 10'd7, 1'b0, 4'h0, 32'h0);
        chk("fw7_rd1", p1_rsp_data, 32'hCAFEF00D);
        step();
        set_p0(1'b0, 10'd0, 1'b0, 4'h0, 32'h0);
        chk("raw7_rd0", p0_rsp_data, 32'hCAFEF00D);

        // Null write behaves as a read
        set_p0(1'b1, 10'd7, 1'b1, 4'h0, 32'h12345678);
        #1;
        chk("nw_ram_we", 32'(ram_we), 32'd0);
        step();
        set_p0(1'b0, 10'd0, 1'b0, 4'h0, 32'h0);
        chk("nw_rd0", p0_rsp_data, 32'hCAFEF00D);

        // Reset during RMW_WR drops the write and the response
        set_p0(1'b1, 10'd5, 1'b1, 4'b1000, 32'hFF000000);
        #1;
        chk("rmr_ready0", 32'(p0_req_ready), 32'd1);
        step();
        reset = 1'b1;
        set_p0(1'b1, 10'd5, 1'b0, 4'h0, 32'h0);
        set_p1(1'b1, 10'd3, 1'b0, 4'h0, 32'h0);
        #1;
        chk("rmr_ram_we", 32'(ram_we), 32'd0);
        chk("rmr_ready1", 32'(p1_req_ready), 32'd0);
        step();
        reset = 1'b0;
        chk("rmr_rv0", 32'(p0_rsp_valid), 32'd0);
        chk("rmr_rv1", 32'(p1_rsp_valid), 32'd0);
        #1;
        chk("rmr_win0", 32'(p0_req_ready), 32'd1);
        chk("rmr_lose1", 32'(p1_req_ready), 32'd0);
        step();
        set_p0(1'b0, 10'd0, 1'b0, 4'h0, 32'h0);
        set_p1(1'b0, 10'd0, 1'b0, 4'h0, 32'h0);
        chk("rmr_rv0_after", 32'(p0_rsp_valid), 32'd1);
        chk("rmr_mem_kept", p0_rsp_data, 32'hDEADBEEF);
        step();
        chk("rmr_rv1_after", 32'(p1_rsp_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
